apb_req_arbiter: RTL and testbench

- Shares one APB bridge transfer port (trnsfr/wr/address/data_in/data_out) between NREQ independent requesters.
- Arbitrates round-robin, latches the winner's command and drives the bridge until the bridge signals completion.
- Returns read data and a one-cycle done/err pulse to the winner; a watchdog aborts transfers that stall.
- Sits between the system requesters and the bridge's transfer inputs.

---
 rtl/apb_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB bridge transfer port between NREQ requesters.
// The winner's command is latched for the whole transfer, and a watchdog aborts stalled transfers.
module apb_req_arbiter #(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_wr,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic                       err,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       trnsfr,
    output logic                       wr,
    output logic [ADDR_WIDTH-1:0]      address,
    output logic [DATA_WIDTH-1:0]      data_in,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic                       xfer_done
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        last_q;
    logic [IDX_W-1:0]        cur_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NREQ-1:0]         gnt_q;
    logic [NREQ-1:0]         done_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    trnsfr_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   address_q;
    logic [DATA_WIDTH-1:0]   data_in_q;

    logic                    sel_vld_d;
    logic [IDX_W-1:0]        sel_idx_d;
    logic [ADDR_WIDTH-1:0]   addr_arr [NREQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NREQ];

    // Search starts just after the last winner, so the smallest offset wins.
    function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [IDX_W-1:0] last);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (r[IDX_W'(idx)]) begin
                res = {1'b1, IDX_W'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return NREQ'(1) << i;
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        sel_vld_d = 1'b0;
        sel_idx_d = '0;
        {sel_vld_d, sel_idx_d} = rr_pick(req, last_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= IDX_W'(NREQ - 1);
            cur_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            trnsfr_q  <= 1'b0;
            wr_q      <= 1'b0;
            address_q <= '0;
            data_in_q <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_vld_d) begin
                        cur_q     <= sel_idx_d;
                        gnt_q     <= onehot(sel_idx_d);
                        trnsfr_q  <= 1'b1;
                        wr_q      <= req_wr[sel_idx_d];
                        address_q <= addr_arr[sel_idx_d];
                        data_in_q <= wdata_arr[sel_idx_d];
                        cnt_q     <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Bridge completion takes precedence over a coincident timeout.
                    if (xfer_done) begin
                        trnsfr_q <= 1'b0;
                        gnt_q    <= '0;
                        done_q   <= onehot(cur_q);
                        last_q   <= cur_q;
                        state_q  <= DONE;
                        if (!wr_q) begin
                            rdata_q <= data_out;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        trnsfr_q <= 1'b0;
                        gnt_q    <= '0;
                        done_q   <= onehot(cur_q);
                        err_q    <= 1'b1;
                        last_q   <= cur_q;
                        state_q  <= DONE;
                        if (!wr_q) begin
                            rdata_q <= '0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign trnsfr  = trnsfr_q;
    assign wr      = wr_q;
    assign address = address_q;
    assign data_in = data_in_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a scoreboard queue holds each expected transfer,
// popped and checked when the arbiter pulses done.
module tb_apb_req_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int TO   = 16;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [DW-1:0]        rdata;
    logic                 trnsfr;
    logic                 wr;
    logic [AW-1:0]        address;
    logic [DW-1:0]        data_in;
    logic [DW-1:0]        data_out;
    logic                 xfer_done;

    typedef struct {
        logic [NREQ-1:0] onehot;
        logic            wr;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic            err;
        logic [DW-1:0]   rdata;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] model_rdata;
    int            n_chk;
    int            n_fail;

    apb_req_arbiter #(
        .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .trnsfr(trnsfr), .wr(wr), .address(address),
        .data_in(data_in), .data_out(data_out), .xfer_done(xfer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "stuck");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i]            = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic push(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic e, input logic [DW-1:0] r);
        exp_t x;
        x.onehot = NREQ'(1) << i;
        x.wr     = w;
        x.addr   = a;
        x.wdata  = d;
        x.err    = e;
        x.rdata  = r;
        sbq.push_back(x);
    endtask

    // Called at the falling edge on which req becomes visible; plays the bridge.
    task automatic xfer(input int idx, input int lat, input logic [DW-1:0] dout, input int exp_busy,
                        input bit drop, input bit mutate);
        exp_t          e;
        int            n;
        int            busy;
        logic [DW-1:0] exp_r;
        e = sbq[0];
        n = 0;
        while (trnsfr !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("trnsfr_rise", trnsfr, 1);
        busy = 0;
        n    = 0;
        while (done === '0 && n < TO + 6) begin
            if (trnsfr === 1'b1) begin
                busy++;
                chk("hold_gnt", gnt, e.onehot);
                chk("hold_addr", address, e.addr);
                chk("hold_wr", wr, e.wr);
                if (e.wr) chk("hold_data_in", data_in, e.wdata);
                if (mutate && busy == 1) begin
                    req_wdata[idx*DW +: DW] = 32'hFFFF_0000;
                    req_addr[idx*AW +: AW]  = 8'hFF;
                    req_wr[idx]             = ~req_wr[idx];
                    req[idx]                = 1'b0;
                end
            end
            data_out  = dout;
            xfer_done = (lat != 0 && busy == lat);
            @(negedge clk);
            n++;
        end
        xfer_done = 1'b0;
        chk("done_arrived", (done !== '0), 1);
        chk("busy_cycles", busy, exp_busy);
        e = sbq.pop_front();
        exp_r = e.wr ? model_rdata : e.rdata;
        model_rdata = exp_r;
        chk("done", done, e.onehot);
        chk("err", err, e.err);
        chk("rdata", rdata, exp_r);
        chk("trnsfr_off", trnsfr, 0);
        chk("gnt_off", gnt, 0);
        if (drop) req[idx] = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("err_clear", err, 0);
        chk("rdata_hold", rdata, exp_r);
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        model_rdata = '0;
        rst_n       = 1'b0;
        req         = '0;
        req_wr      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        data_out    = '0;
        xfer_done   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_trnsfr", trnsfr, 0);
        chk("rst_wr", wr, 0);
        chk("rst_address", address, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read from requester 0.
        set_req(0, 1'b0, 8'h10, 32'h0);
        push(0, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        req = 4'b0001;
        xfer(0, 2, 32'hDEADBEEF, 2, 1, 0);

        // Bridge completion while idle must be ignored.
        xfer_done = 1'b1;
        data_out  = 32'h5555_5555;
        @(negedge clk);
        xfer_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("idle_done", done, 0);
            chk("idle_trnsfr", trnsfr, 0);
            chk("idle_rdata", rdata, 32'hDEADBEEF);
            @(negedge clk);
        end

        // Write whose requester fields change mid-transfer.
        set_req(2, 1'b1, 8'h3C, 32'h12345678);
        push(2, 1'b1, 8'h3C, 32'h12345678, 1'b0, 32'h0);
        req = 4'b0100;
        xfer(2, 3, 32'hCAFE_F00D, 3, 1, 1);

        // Read that stalls until the watchdog fires.
        set_req(1, 1'b0, 8'h21, 32'h0);
        push(1, 1'b0, 8'h21, 32'h0, 1'b1, 32'h0);
        req = 4'b0010;
        xfer(1, 0, 32'hBAD0_BAD0, TO, 1, 0);

        // Completion in the very cycle the watchdog would fire.
        set_req(3, 1'b0, 8'h33, 32'h0);
        push(3, 1'b0, 8'h33, 32'h0, 1'b0, 32'hA5A5_5A5A);
        req = 4'b1000;
        xfer(3, TO, 32'hA5A5_5A5A, TO, 1, 0);

        // Round robin with all requesters held high.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(8'h40 + i), 32'h0);
        req = 4'b1111;
        begin
            int order[7] = '{0, 1, 2, 3, 0, 1, 2};
            for (int k = 0; k < 7; k++) begin
                push(order[k], 1'b0, AW'(8'h40 + order[k]), 32'h0, 1'b0, DW'(32'h1000 + k));
                xfer(order[k], 1, DW'(32'h1000 + k), 1, 0, 0);
            end
        end
        req = 4'b1001;
        push(3, 1'b0, 8'h43, 32'h0, 1'b0, 32'h2000);
        xfer(3, 1, 32'h2000, 1, 0, 0);
        req = '0;
        @(negedge clk);

        // Set pointer to 0, then reset in the middle of requester 1's transfer.
        set_req(0, 1'b0, 8'h50, 32'h0);
        push(0, 1'b0, 8'h50, 32'h0, 1'b0, 32'h3000);
        req = 4'b0001;
        xfer(0, 1, 32'h3000, 1, 1, 0);
        set_req(1, 1'b0, 8'h51, 32'h0);
        req = 4'b0010;
        repeat (3) @(negedge clk);
        chk("pre_rst_trnsfr", trnsfr, 1);
        chk("pre_rst_gnt", gnt, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("async_trnsfr", trnsfr, 0);
        chk("async_gnt", gnt, 0);
        chk("async_done", done, 0);
        chk("async_rdata", rdata, 0);
        model_rdata = '0;
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_trnsfr", trnsfr, 0);
        end

        // Pointer restarts at priority 0 after reset.
        set_req(0, 1'b0, 8'h60, 32'h0);
        set_req(2, 1'b0, 8'h62, 32'h0);
        push(0, 1'b0, 8'h60, 32'h0, 1'b0, 32'h4000);
        req = 4'b0101;
        xfer(0, 1, 32'h4000, 1, 1, 0);
        push(2, 1'b0, 8'h62, 32'h0, 1'b0, 32'h4002);
        xfer(2, 2, 32'h4002, 2, 1, 0);
        req = '0;
        repeat (2) @(negedge clk);
        chk("final_idle_trnsfr", trnsfr, 0);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
